// File: rtl/sha3_block_padder.sv
// SHA3-512 transmit-side padder: packs 64-bit message words into 576-bit rate
// blocks, applies 0x06..0x80 padding and hands blocks to the Keccak core.
module sha3_block_padder #(
    parameter int RATE_BITS = 576,
    parameter int WORD_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_BITS-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [3:0]           in_bytes,
    output logic                 in_ready,
    output logic [RATE_BITS-1:0] blk_data,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic                 blk_first,
    output logic                 blk_last,
    output logic                 busy
);

    localparam int NW = RATE_BITS / WORD_BITS;
    localparam int WB = WORD_BITS / 8;
    localparam int CW = $clog2(NW + 1);

    localparam logic [RATE_BITS-1:0] PAD_ONLY_BLK = {8'h80, {(RATE_BITS-16){1'b0}}, 8'h06};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t               state_r, state_n;
    logic [RATE_BITS-1:0] buf_r, buf_n;
    logic [CW-1:0]        cnt_r, cnt_n;
    logic                 first_r, first_n;
    logic                 pad_r, pad_n;
    logic                 last_r, last_n;

    logic                 in_ready_r, blk_valid_r, blk_first_r, blk_last_r, busy_r;
    logic [3:0]           n_s;
    logic                 full_s;
    logic                 last_slot_s;
    logic [WORD_BITS-1:0] slot_s;

    // Keeps bytes below n, places the 0x06 delimiter at byte n, zeroes the rest.
    function automatic logic [WORD_BITS-1:0] pad_word(input logic [WORD_BITS-1:0] data,
                                                      input logic [3:0] n);
        logic [WORD_BITS-1:0] w;
        w = {WORD_BITS{1'b0}};
        for (int j = 0; j < WB; j++) begin
            if (j < int'(n)) begin
                w[8*j +: 8] = data[8*j +: 8];
            end else if (j == int'(n)) begin
                w[8*j +: 8] = 8'h06;
            end else begin
                w[8*j +: 8] = 8'h00;
            end
        end
        return w;
    endfunction

    // Byte count clamping and the word value written into the current slot.
    always_comb begin
        n_s         = (in_bytes > 4'(WB)) ? 4'(WB) : in_bytes;
        full_s      = (n_s == 4'(WB));
        last_slot_s = (cnt_r == CW'(NW - 1));
        slot_s      = in_last ? pad_word(in_data, n_s) : in_data;
    end

    // Next-state logic: block assembly, padding and send handshake.
    always_comb begin
        state_n = state_r;
        buf_n   = buf_r;
        cnt_n   = cnt_r;
        first_n = first_r;
        pad_n   = pad_r;
        last_n  = last_r;
        case (state_r)
            ST_IDLE: begin
                state_n = ST_FILL;
                first_n = 1'b1;
            end
            ST_FILL: begin
                if (in_valid && in_ready_r) begin
                    // A full last word before slot 8 pushes the delimiter into the next (empty) slot.
                    for (int k = 0; k < NW; k++) begin
                        if (k == int'(cnt_r)) begin
                            buf_n[k*WORD_BITS +: WORD_BITS] = slot_s;
                        end else if (in_last && full_s && (k == int'(cnt_r) + 1)) begin
                            buf_n[k*WORD_BITS +: WORD_BITS] = {{(WORD_BITS-8){1'b0}}, 8'h06};
                        end else begin
                            buf_n[k*WORD_BITS +: WORD_BITS] = buf_r[k*WORD_BITS +: WORD_BITS];
                        end
                    end
                    cnt_n = cnt_r + CW'(1);
                    if (in_last) begin
                        state_n = ST_SEND;
                        if (last_slot_s && full_s) begin
                            last_n = 1'b0;
                            pad_n  = 1'b1;
                        end else begin
                            last_n = 1'b1;
                            pad_n  = 1'b0;
                            buf_n[RATE_BITS-1 -: 8] = buf_n[RATE_BITS-1 -: 8] | 8'h80;
                        end
                    end else if (last_slot_s) begin
                        state_n = ST_SEND;
                        last_n  = 1'b0;
                        pad_n   = 1'b0;
                    end else begin
                        state_n = ST_FILL;
                    end
                end else begin
                    state_n = ST_FILL;
                end
            end
            ST_SEND: begin
                if (blk_ready) begin
                    buf_n   = {RATE_BITS{1'b0}};
                    cnt_n   = CW'(0);
                    first_n = 1'b0;
                    if (pad_r) begin
                        buf_n   = PAD_ONLY_BLK;
                        pad_n   = 1'b0;
                        last_n  = 1'b1;
                        state_n = ST_SEND;
                    end else if (last_r) begin
                        first_n = 1'b1;
                        state_n = ST_FILL;
                    end else begin
                        state_n = ST_FILL;
                    end
                end else begin
                    state_n = ST_SEND;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs are decoded from next-state values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            buf_r       <= {RATE_BITS{1'b0}};
            cnt_r       <= CW'(0);
            first_r     <= 1'b1;
            pad_r       <= 1'b0;
            last_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            blk_valid_r <= 1'b0;
            blk_first_r <= 1'b0;
            blk_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            buf_r       <= buf_n;
            cnt_r       <= cnt_n;
            first_r     <= first_n;
            pad_r       <= pad_n;
            last_r      <= last_n;
            in_ready_r  <= (state_n == ST_FILL);
            blk_valid_r <= (state_n == ST_SEND);
            blk_first_r <= (state_n == ST_SEND) && first_n;
            blk_last_r  <= (state_n == ST_SEND) && last_n;
            busy_r      <= (cnt_n != CW'(0)) || (state_n == ST_SEND) || !first_n;
        end
    end

    assign in_ready  = in_ready_r;
    assign blk_data  = buf_r;
    assign blk_valid = blk_valid_r;
    assign blk_first = blk_first_r;
    assign blk_last  = blk_last_r;
    assign busy      = busy_r;

endmodule
